// File: rtl/mux3_rr_sel_pkg.sv
// Shared select codes, FSM state type and grant-to-select decode for mux3_rr_sel.
package mux3_rr_sel_pkg;

  localparam logic [1:0] SEL_I0 = 2'b00;
  localparam logic [1:0] SEL_I1 = 2'b01;
  localparam logic [1:0] SEL_I2 = 2'b10;

  typedef enum logic {ST_IDLE, ST_GRANT} state_e;

  // An all-zero grant decodes to SEL_I0.
  function automatic logic [1:0] onehot3_to_sel(input logic [2:0] oh);
    if (oh[2]) return SEL_I2;
    if (oh[1]) return SEL_I1;
    return SEL_I0;
  endfunction

endpackage

// File: rtl/mux3_rr_sel_rr_pick3.sv
// Combinational 3-way round-robin picker: the first requester at or after ptr, cyclically.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] winner,
  output logic       any_req
);

  logic [2:0] idx;
  logic       found;

  always_comb begin
    winner = 3'b000;
    found  = 1'b0;
    idx    = 3'd0;
    for (int i = 0; i < 3; i++) begin
      idx = {1'b0, ptr} + 3'(i);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && req[idx[1:0]]) begin
        winner[idx[1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mux3_rr_sel.sv
// Round-robin select generator for a 3:1 mux with bounded grant bursts.
// Optional macro MUX3_RR_SEL_PARK_EN: hold the last grantee's select code while idle.
module mux3_rr_sel
  import mux3_rr_sel_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic       s0,
  output logic       s1,
  output logic [2:0] gnt,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0] cur_sel, ptr_adv, arb_ptr;
  logic [2:0] winner;
  logic       any_req, grant_held, full_end, early_end;

  rr_pick3 u_pick (
    .req    (req),
    .ptr    (arb_ptr),
    .winner (winner),
    .any_req(any_req)
  );

  always_comb begin
    cur_sel    = onehot3_to_sel(gnt_q);
    grant_held = |(req & gnt_q);
    full_end   = (cnt_q == CntLast);
    ptr_adv    = (cur_sel == SEL_I2) ? 2'd0 : cur_sel + 2'd1;
    // When a grant ends, arbitration already uses the advanced pointer.
    arb_ptr    = (state_q == ST_GRANT) ? ptr_adv : ptr_q;

    state_d   = state_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    early_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          gnt_d   = winner;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (grant_held && !full_end) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          ptr_d     = ptr_adv;
          early_end = !full_end;
          cnt_d     = '0;
          if (any_req) begin
            gnt_d = winner;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 3'b000;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 3'b000;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_GRANT);
    // Full-length bursts flag done in their last held cycle; early releases flag it one late.
    done_d = ((state_d == ST_GRANT) && (cnt_d == CntLast)) || early_end;

`ifdef MUX3_RR_SEL_PARK_EN
    sel_d = (state_d == ST_GRANT) ? onehot3_to_sel(gnt_d) : sel_q;
`else
    sel_d = onehot3_to_sel(gnt_d);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 3'b000;
      cnt_q   <= '0;
      ptr_q   <= 2'd0;
      sel_q   <= SEL_I0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gnt  = gnt_q;
  assign s1   = sel_q[1];
  assign s0   = sel_q[0];
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mux3_rr_sel.sv
// Self-checking bench for mux3_rr_sel: directed scenarios plus randomized requests vs a model.
module tb_mux3_rr_sel;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       s0, s1, busy, done;
  logic [2:0] gnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: current grantee (-1 = idle), cycles held so far (1-based), rotation start, last grantee.
  int m_cur, m_age, m_ptr, m_last;
  bit m_done;

  mux3_rr_sel #(.HOLD_CYCLES(H), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .s0  (s0),
    .s1  (s1),
    .gnt (gnt),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [2:0] q, input int p);
    for (int k = 0; k < 3; k++) begin
      if (q[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_step(input bit r, input logic [2:0] q);
    bit early;
    early = 1'b0;
    if (r) begin
      m_cur = -1; m_age = 0; m_ptr = 0; m_last = 0; m_done = 1'b0;
      return;
    end
    if (m_cur < 0) begin
      if (q != 3'b000) begin
        m_cur = pick(q, m_ptr);
        m_age = 1;
      end
    end else if (q[m_cur] && m_age < H) begin
      m_age++;
    end else begin
      early = (m_age < H);
      m_ptr = (m_cur + 1) % 3;
      if (q != 3'b000) begin
        m_cur = pick(q, m_ptr);
        m_age = 1;
      end else begin
        m_cur = -1;
        m_age = 0;
      end
    end
    m_done = early || (m_cur >= 0 && m_age == H);
    if (m_cur >= 0) m_last = m_cur;
  endtask

  function automatic logic [6:0] model_out();
    logic [2:0] g;
    logic [1:0] sel;
    g = (m_cur < 0) ? 3'b000 : 3'(1 << m_cur);
`ifdef MUX3_RR_SEL_PARK_EN
    sel = (m_cur < 0) ? 2'(m_last) : 2'(m_cur);
`else
    sel = (m_cur < 0) ? 2'b00 : 2'(m_cur);
`endif
    return {g, sel, (m_cur >= 0), m_done};
  endfunction

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, got, exp);
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs after the edge.
  task automatic cycle(input bit r, input logic [2:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    model_step(r, q);
    #1;
    chk("model", {gnt, s1, s0, busy, done}, model_out());
  endtask

  logic [1:0] park_sel;
  logic [2:0] rq;

  initial begin
`ifdef MUX3_RR_SEL_PARK_EN
    park_sel = 2'b10;
`else
    park_sel = 2'b00;
`endif
    rst = 1'b1;
    req = 3'b111;

    // Reset with all requests pending, then round-robin over i0, i1, i2, i0.
    cycle(1'b1, 3'b111);
    cycle(1'b1, 3'b111);
    chk("reset_out", {gnt, s1, s0, busy, done}, 7'b000_00_0_0);
    cycle(1'b0, 3'b111);
    chk("first_grant", {gnt, s1, s0, busy, done}, 7'b001_00_1_0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'b111);
    chk("rr_i0_done", {gnt, s1, s0, busy, done}, 7'b001_00_1_1);
    cycle(1'b0, 3'b111);
    chk("rr_i1", {gnt, s1, s0, busy, done}, 7'b010_01_1_0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'b111);
    chk("rr_i1_done", {gnt, s1, s0, busy, done}, 7'b010_01_1_1);
    cycle(1'b0, 3'b111);
    chk("rr_i2", {gnt, s1, s0, busy, done}, 7'b100_10_1_0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'b111);
    cycle(1'b0, 3'b111);
    chk("rr_wrap_i0", {gnt, s1, s0, busy, done}, 7'b001_00_1_0);

    // Full-length hold of a lone requester, then re-grant with no gap.
    cycle(1'b1, 3'b000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'b001);
    chk("hold_3rd", {gnt, s1, s0, busy, done}, 7'b001_00_1_0);
    cycle(1'b0, 3'b001);
    chk("hold_4th_done", {gnt, s1, s0, busy, done}, 7'b001_00_1_1);
    cycle(1'b0, 3'b001);
    chk("hold_regrant", {gnt, s1, s0, busy, done}, 7'b001_00_1_0);

    // Early release of i1 hands over to i2 with done in the handover cycle.
    cycle(1'b1, 3'b000);
    cycle(1'b0, 3'b010);
    cycle(1'b0, 3'b110);
    chk("early_pre", {gnt, s1, s0, busy, done}, 7'b010_01_1_0);
    cycle(1'b0, 3'b100);
    chk("early_handover", {gnt, s1, s0, busy, done}, 7'b100_10_1_1);

    // i2 releases with nobody waiting: idle, select parked or forced to i0.
    cycle(1'b0, 3'b000);
    chk("idle_release", {gnt, s1, s0, busy, done}, {3'b000, park_sel, 1'b0, 1'b1});
    cycle(1'b0, 3'b000);
    chk("idle_park", {gnt, s1, s0, busy, done}, {3'b000, park_sel, 1'b0, 1'b0});

    // Reset during i2 burst at count 2; pointer returns to i0 so i1 beats i2.
    cycle(1'b1, 3'b000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'b100);
    chk("mid_pre", {gnt, s1, s0, busy, done}, 7'b100_10_1_0);
    cycle(1'b1, 3'b100);
    chk("mid_reset", {gnt, s1, s0, busy, done}, 7'b000_00_0_0);
    cycle(1'b0, 3'b110);
    chk("mid_after", {gnt, s1, s0, busy, done}, 7'b010_01_1_0);

    // Randomized requests with sticky bits and occasional resets.
    rq = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      end
      cycle(($urandom_range(99) == 0), rq);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux3_rr_sel.md
Name: mux3_rr_sel

Overview:
- Upstream select generator for the 3:1 mux stage.
- Round-robin arbitrates three request lines (one per mux data input i0/i1/i2) and drives the mux selects s1/s0 plus a one-hot grant.
- Holds each grant for a bounded burst so the registered mux output carries a stable source for a known number of cycles.

Parameters:
- HOLD_CYCLES, 4, maximum cycles a single grant is held (legal range 1..15).
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  3  request per source; bit n requests mux input in.
- s0   output 1  mux select LSB.
- s1   output 1  mux select MSB.
- gnt  output 3  one-hot grant, aligned with s1/s0.
- busy output 1  high while any grant is active.
- done output 1  one-cycle pulse in the final cycle of a grant.

Behaviour:
- Select encoding {s1,s0}: 00=i0, 01=i1, 10=i2. 11 is never driven.
- Reset state:
  - Sampled rst=1 gives, next cycle: gnt=000, {s1,s0}=00, busy=0, done=0, hold counter=0, state IDLE.
  - Priority pointer resets so the order is i0>i1>i2.
- All outputs are registered. s1/s0 decode directly from the gnt register.
- FSM states:
  - IDLE -> GRANT when any req bit is sampled high. The winner is the first requester at or after the pointer, cyclically.
  - GRANT -> GRANT (same grantee) while req[g]=1 and count < HOLD_CYCLES-1.
  - GRANT end: the grant ends when count = HOLD_CYCLES-1, or req[g] is sampled low.
  - On grant end, the pointer moves to g+1 mod 3.
  - GRANT -> GRANT (new grantee) if any other req is pending at the end edge. No idle gap.
  - GRANT -> IDLE otherwise.
- Latency: req high at edge N gives gnt/select valid from cycle N+1.
- Counter:
  - Cleared on each new grant and increments each GRANT cycle.
  - Saturating compare; no wrap is visible.
- done:
  - Asserted in the last cycle gnt is held for the current grantee.
  - On a full-length hold, this is the cycle where count = HOLD_CYCLES-1.
  - On early release (req[g] sampled low), done is asserted in the cycle following that edge, alongside the new grant or the return to IDLE. gnt is already updated in that cycle.
- Re-arbitration: if only the current grantee is still requesting at a full-length end, it is re-granted with a fresh count. The pointer still advances.
- Simultaneous requests: the pointer decides. No two gnt bits are ever high together.
- HOLD_CYCLES=1: a new arbitration happens every cycle, giving pure round-robin.
- Reset mid-grant: synchronous reset overrides all transitions. No done pulse is generated.

Optional Feature:
- Macro: MUX3_RR_SEL_PARK_EN.
- Defined: in IDLE, {s1,s0} stays at the last grantee's code ("park") while gnt=000. Reset still forces 00.
- Undefined: IDLE forces {s1,s0}=00.

Decomposition:
- Package mux3_rr_sel_pkg holds:
  - Select codes SEL_I0=2'b00, SEL_I1=2'b01, SEL_I2=2'b10.
  - State enum {ST_IDLE, ST_GRANT}.
  - Function onehot3_to_sel.
- Sub-module rr_pick3: purely combinational. Takes req[2:0] and pointer[1:0] and returns a one-hot winner plus any_req. It is instantiated once.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with req=111, then release. Required: gnt=000, sel=00 during reset; first post-reset cycle gives gnt=001, sel=00.
- Full hold: req=001 held with HOLD_CYCLES=4. Required: gnt=001 for 4 cycles, done on the 4th, then re-grant of i0 with no gap.
- Round-robin: req=111 constant. Required: grant sequence i0,i1,i2,i0 (sel 00,01,10,00), each 4 cycles, and done on every 4th cycle.
- Early release: grant i1, then drop req[1] after 2 cycles with req[2]=1. Required: next cycle gnt=100, sel=10, done=1 in that same cycle.
- Mid-op reset: assert rst during i2 grant at count=2. Required: next cycle gnt=000, busy=0, no done; after release with req=110, i1 wins (pointer reset).
- Park: with MUX3_RR_SEL_PARK_EN defined, after i2 grant ends with req=000, sel stays 10 while gnt=000. Without the macro, sel=00.
